// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - diagonal-skew operand feeder for a row of FP32 MAC PEs
// Lane i sees each accepted operand i+1 cycles after transfer, tagged with tile first/last.
module systolic_skew_feeder #(
  parameter int N      = 4,
  parameter int K      = 4,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid,
  output logic [N-1:0]        out_first,
  output logic [N-1:0]        out_last,
  output logic                tile_done,
  output logic                busy
);

  localparam int CNT_W = $clog2(K + 1);
  localparam int FL_W  = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);
  localparam logic [FL_W-1:0]  FL_END   = FL_W'(N - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [FL_W-1:0]    fcnt, fcnt_d;
  logic               xfer;

  logic [N*DATA_W-1:0] s0_data;
  logic                s0_valid;
  logic                s0_first;
  logic                s0_last;

  assign in_ready = (state != FLUSH);
  assign xfer     = in_valid & in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      fcnt  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      fcnt  <= fcnt_d;
    end
  end

  // IDLE accepts like FEED; with cnt==0 in IDLE, K=1 jumps straight to FLUSH.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    fcnt_d  = fcnt;
    case (state)
      IDLE, FEED: begin
        if (xfer) begin
          cnt_d = cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state_d = FLUSH;
            fcnt_d  = '0;
          end else begin
            state_d = FEED;
          end
        end
      end
      FLUSH: begin
        if (fcnt == FL_END) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          fcnt_d = fcnt + FL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        fcnt_d  = '0;
      end
    endcase
  end

  // Non-transfer slots enter as zero data so downstream adds see FP +0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_data  <= '0;
      s0_valid <= 1'b0;
      s0_first <= 1'b0;
      s0_last  <= 1'b0;
    end else begin
      s0_data  <= xfer ? in_data : '0;
      s0_valid <= xfer;
      s0_first <= xfer & (cnt == '0);
      s0_last  <= xfer & (cnt == LAST_CNT);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    if (i == 0) begin : g_direct
      assign out_data[0 +: DATA_W] = s0_data[0 +: DATA_W];
      assign out_valid[0]          = s0_valid;
      assign out_first[0]          = s0_first;
      assign out_last[0]           = s0_last;
    end else begin : g_delay
      logic [DATA_W-1:0] d_q [i];
      logic [i-1:0]      v_q;
      logic [i-1:0]      f_q;
      logic [i-1:0]      l_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int j = 0; j < i; j++) begin
            d_q[j] <= '0;
          end
          v_q <= '0;
          f_q <= '0;
          l_q <= '0;
        end else begin
          d_q[0] <= s0_data[i*DATA_W +: DATA_W];
          v_q[0] <= s0_valid;
          f_q[0] <= s0_first;
          l_q[0] <= s0_last;
          for (int j = 1; j < i; j++) begin
            d_q[j] <= d_q[j-1];
            v_q[j] <= v_q[j-1];
            f_q[j] <= f_q[j-1];
            l_q[j] <= l_q[j-1];
          end
        end
      end

      assign out_data[i*DATA_W +: DATA_W] = d_q[i-1];
      assign out_valid[i]                 = v_q[i-1];
      assign out_first[i]                 = f_q[i-1];
      assign out_last[i]                  = l_q[i-1];
    end
  end

  // out_last is only ever set on a valid slot, so it alone marks the tile end.
  assign tile_done = out_last[N-1];

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - self-checking bench for systolic_skew_feeder
// Two instances: N=4,K=3 (main) and N=4,K=1.
module tb_systolic_skew_feeder;

  logic         clk;
  logic         rst;
  logic [127:0] in_data0, in_data1;
  logic         in_valid0, in_valid1;
  logic         in_ready0, in_ready1;
  logic [127:0] out_data0, out_data1;
  logic [3:0]   out_valid0, out_valid1;
  logic [3:0]   out_first0, out_first1;
  logic [3:0]   out_last0, out_last1;
  logic         tile_done0, tile_done1;
  logic         busy0, busy1;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  systolic_skew_feeder #(.N(4), .K(3), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .out_data(out_data0), .out_valid(out_valid0), .out_first(out_first0), .out_last(out_last0),
    .tile_done(tile_done0), .busy(busy0)
  );

  systolic_skew_feeder #(.N(4), .K(1), .DATA_W(32)) dut_k1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_data(out_data1), .out_valid(out_valid1), .out_first(out_first1), .out_last(out_last1),
    .tile_done(tile_done1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] vec(input int t, input int e);
    logic [127:0] v;
    for (int j = 0; j < 4; j++) v[j*32 +: 32] = 32'h3F80_0000 + 32'(t << 16) + 32'(e << 8) + 32'(j);
    return v;
  endfunction

  // Model: every accepted element is logged by acceptance cycle; lane i shows
  // the element accepted at cycle c-1-i. Readiness follows the tile rule:
  // after the K-th element of a tile, N-1 cycles of no acceptance.
  logic [127:0] hd [2][0:1023];
  bit           hv [2][0:1023];
  bit           hf [2][0:1023];
  bit           hl [2][0:1023];
  int           elem [2];
  int           fl [2];

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int kk;
      int src;
      logic [127:0] ed, ad;
      logic [3:0]   ev, ef, el, av, af, al;
      logic         exp_ready, exp_busy, a_ready, a_busy, a_done, a_iv;
      logic [127:0] a_id;
      kk = (m == 0) ? 3 : 1;
      if (m == 0) begin
        ad = out_data0; av = out_valid0; af = out_first0; al = out_last0;
        a_ready = in_ready0; a_busy = busy0; a_done = tile_done0; a_iv = in_valid0; a_id = in_data0;
      end else begin
        ad = out_data1; av = out_valid1; af = out_first1; al = out_last1;
        a_ready = in_ready1; a_busy = busy1; a_done = tile_done1; a_iv = in_valid1; a_id = in_data1;
      end
      if (rst) begin
        elem[m] = 0;
        fl[m]   = 0;
        for (int c = 0; c <= cyc && c < 1024; c++) hv[m][c] = 1'b0;
      end
      exp_ready = (fl[m] == 0);
      exp_busy  = (elem[m] != 0) || (fl[m] != 0);
      ed = '0; ev = '0; ef = '0; el = '0;
      for (int i = 0; i < 4; i++) begin
        src = cyc - 1 - i;
        if (src >= 0 && hv[m][src]) begin
          ev[i] = 1'b1;
          ef[i] = hf[m][src];
          el[i] = hl[m][src];
          ed[i*32 +: 32] = hd[m][src][i*32 +: 32];
        end
      end
      chk($sformatf("u%0d in_ready", m), {127'b0, a_ready}, {127'b0, exp_ready});
      chk($sformatf("u%0d busy", m), {127'b0, a_busy}, {127'b0, exp_busy});
      chk($sformatf("u%0d tile_done", m), {127'b0, a_done}, {127'b0, el[3]});
      chk($sformatf("u%0d out_valid", m), {124'b0, av}, {124'b0, ev});
      chk($sformatf("u%0d out_first", m), {124'b0, af}, {124'b0, ef});
      chk($sformatf("u%0d out_last", m), {124'b0, al}, {124'b0, el});
      chk($sformatf("u%0d out_data", m), ad, ed);
      if (!rst) begin
        hv[m][cyc] = 1'b0;
        if (a_iv && exp_ready) begin
          hv[m][cyc] = 1'b1;
          hd[m][cyc] = a_id;
          hf[m][cyc] = (elem[m] == 0);
          hl[m][cyc] = (elem[m] == kk - 1);
          elem[m]++;
        end
        if (fl[m] > 0) fl[m]--;
        if (elem[m] == kk) begin
          elem[m] = 0;
          fl[m]   = 3;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int t);
    int lim;
    lim = 0;
    @(negedge clk);
    while (cyc < t && lim < 500) begin
      @(negedge clk);
      lim++;
    end
    nvec++;
    if (cyc != t) begin
      nerr++;
      $display("FAIL at_cycle: reached %0d required %0d", cyc, t);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s;
    logic [31:0]  fp [3];
    logic [127:0] tmp;
    fp[0] = 32'h3F80_0000; fp[1] = 32'h4000_0000; fp[2] = 32'h4040_0000;
    rst = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0;
    in_valid1 = 1'b0; in_data1 = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset in_ready", {127'b0, in_ready0}, 128'd1);
    chk("reset busy", {127'b0, busy0}, 128'd0);
    chk("reset out_valid", {124'b0, out_valid0}, 128'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single tile, all lanes 1.0 / 2.0 / 3.0
    s = cyc;
    for (int e = 0; e < 3; e++) begin
      in_valid0 = 1'b1;
      in_data0  = {4{fp[e]}};
      tick();
    end
    in_valid0 = 1'b0;
    in_data0  = '0;
    at_cycle(s + 4);
    chk("single lane3 first", {127'b0, out_first0[3]}, 128'd1);
    chk("single lane3 data0", {96'b0, out_data0[127:96]}, {96'b0, 32'h3F80_0000});
    at_cycle(s + 6);
    chk("single lane3 last", {127'b0, out_last0[3]}, 128'd1);
    chk("single lane3 data2", {96'b0, out_data0[127:96]}, {96'b0, 32'h4040_0000});
    chk("single tile_done", {127'b0, tile_done0}, 128'd1);
    chk("single busy idle", {127'b0, busy0}, 128'd0);

    // Bubble: two idle cycles between elements 1 and 2
    tick();
    s = cyc;
    in_valid0 = 1'b1; in_data0 = vec(1, 0); tick();
    in_data0 = vec(1, 1); tick();
    in_valid0 = 1'b0; in_data0 = '0; tick(); tick();
    in_valid0 = 1'b1; in_data0 = vec(1, 2); tick();
    in_valid0 = 1'b0; in_data0 = '0;
    at_cycle(s + 6);
    chk("bubble lane3 valid", {127'b0, out_valid0[3]}, 128'd0);
    chk("bubble lane3 data", {96'b0, out_data0[127:96]}, 128'd0);
    at_cycle(s + 7);
    chk("bubble early done", {127'b0, tile_done0}, 128'd0);
    at_cycle(s + 8);
    chk("bubble tile_done", {127'b0, tile_done0}, 128'd1);
    tmp = vec(1, 2);
    chk("bubble lane3 last data", {96'b0, out_data0[127:96]}, {96'b0, tmp[127:96]});

    // Backpressure + back-to-back tiles with in_valid held high
    tick();
    s = cyc;
    for (int k = 0; k < 9; k++) begin
      in_valid0 = 1'b1;
      in_data0  = (k < 3) ? vec(2, k) : (k < 7) ? vec(2, 3) : vec(2, k - 3);
      @(negedge clk);
      if (k == 3 || k == 5) chk("bp in_ready low", {127'b0, in_ready0}, 128'd0);
      if (k == 4) chk("b2b lane0 gap", {127'b0, out_valid0[0]}, 128'd0);
      if (k == 6) begin
        chk("bp in_ready back", {127'b0, in_ready0}, 128'd1);
        chk("b2b first done", {127'b0, tile_done0}, 128'd1);
        chk("b2b lane0 gap end", {127'b0, out_valid0[0]}, 128'd0);
      end
      if (k == 7) begin
        tmp = vec(2, 3);
        chk("bp held elem first", {127'b0, out_first0[0]}, 128'd1);
        chk("bp held elem data", {96'b0, out_data0[31:0]}, {96'b0, tmp[31:0]});
      end
      tick();
    end
    in_valid0 = 1'b0;
    in_data0  = '0;
    at_cycle(s + 12);
    chk("b2b second done", {127'b0, tile_done0}, 128'd1);

    // K=1 instance
    tick();
    s = cyc;
    in_valid1 = 1'b1; in_data1 = vec(3, 0); tick();
    in_valid1 = 1'b0; in_data1 = '0;
    at_cycle(s + 1);
    chk("k1 busy", {127'b0, busy1}, 128'd1);
    chk("k1 lane0 first/last", {126'b0, out_first1[0], out_last1[0]}, 128'd3);
    at_cycle(s + 3);
    chk("k1 busy end", {127'b0, busy1}, 128'd1);
    at_cycle(s + 4);
    chk("k1 idle", {127'b0, busy1}, 128'd0);
    chk("k1 tile_done", {127'b0, tile_done1}, 128'd1);
    chk("k1 lane3 first/last", {126'b0, out_first1[3], out_last1[3]}, 128'd3);

    // Reset mid-FEED
    tick();
    s = cyc;
    in_valid0 = 1'b1; in_data0 = vec(4, 0); tick();
    in_data0 = vec(4, 1); tick();
    rst = 1'b1; in_data0 = vec(4, 2);
    @(negedge clk);
    chk("rst out_valid", {124'b0, out_valid0}, 128'd0);
    chk("rst out_data", out_data0, 128'd0);
    chk("rst busy", {127'b0, busy0}, 128'd0);
    chk("rst in_ready", {127'b0, in_ready0}, 128'd1);
    tick();
    rst = 1'b0; in_data0 = vec(5, 0); tick();
    in_data0 = vec(5, 1);
    @(negedge clk);
    tmp = vec(5, 0);
    chk("rst restart first", {127'b0, out_first0[0]}, 128'd1);
    chk("rst restart data", {96'b0, out_data0[31:0]}, {96'b0, tmp[31:0]});
    tick();
    in_data0 = vec(5, 2); tick();
    in_valid0 = 1'b0; in_data0 = '0;
    at_cycle(s + 9);
    chk("rst tile_done", {127'b0, tile_done0}, 128'd1);

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
